// File: rtl/motor_seq_ctrl.sv
// Motor PWM sequencer: arbitrates key/remote commands, enforces enable-low dead time
// around direction changes and stops, and auto-stops after run_cycles ramp cycles.
// Optional macro MOTOR_SEQ_RR_EN selects round-robin arbitration instead of key priority.
module motor_seq_ctrl #(
    parameter int unsigned DEAD_CYCLES = 500,
    parameter int unsigned CNT_W       = 3
) (
    input  logic             div100_clk,
    input  logic             s_rst_n,
    input  logic             key_req,
    input  logic [1:0]       key_cmd,
    input  logic             rmt_req,
    input  logic [1:0]       rmt_cmd,
    output logic             key_ack,
    output logic             rmt_ack,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic             pwm_flag,
    output logic             pwm_enable,
    output logic             pwm_direct,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

    localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);

    state_t           state, state_nxt;
    logic [15:0]      dead_cnt, dead_cnt_nxt;
    logic [CNT_W-1:0] cyc_cnt, cyc_cnt_nxt;
    logic [CNT_W-1:0] run_lim, run_lim_nxt;
    logic             tgt_run, tgt_run_nxt;
    logic             tgt_dir, tgt_dir_nxt;
    logic             auto_stop, auto_stop_nxt;
    logic             key_ack_nxt, rmt_ack_nxt;
    logic             en_nxt, dir_nxt, busy_nxt, done_nxt;

    logic             key_elig, rmt_elig;
    logic             grant_key, grant_rmt;
    logic [1:0]       cmd;
    logic             new_dir;
    logic             complete;

    assign key_elig = key_req & ~key_ack;
    assign rmt_elig = rmt_req & ~rmt_ack;

`ifdef MOTOR_SEQ_RR_EN
    // last_rmt = 1 when the remote was granted most recently; reset favours the key.
    logic last_rmt;

    assign grant_key = key_elig & (~rmt_elig | last_rmt);
    assign grant_rmt = rmt_elig & ~grant_key;

    always_ff @(posedge div100_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            last_rmt <= 1'b1;
        end else if (key_ack_nxt) begin
            last_rmt <= 1'b0;
        end else if (rmt_ack_nxt) begin
            last_rmt <= 1'b1;
        end
    end
`else
    assign grant_key = key_elig;
    assign grant_rmt = rmt_elig & ~key_elig;
`endif

    assign cmd      = grant_key ? key_cmd : rmt_cmd;
    assign complete = (state == S_RUN) && pwm_flag && (run_lim != '0) &&
                      ((cyc_cnt + CNT_W'(1)) == run_lim);

    always_comb begin
        unique case (cmd)
            2'b01:   new_dir = 1'b1;
            2'b10:   new_dir = 1'b0;
            default: new_dir = ~pwm_direct;
        endcase
    end

    always_comb begin
        state_nxt     = state;
        dead_cnt_nxt  = dead_cnt;
        cyc_cnt_nxt   = cyc_cnt;
        run_lim_nxt   = run_lim;
        tgt_run_nxt   = tgt_run;
        tgt_dir_nxt   = tgt_dir;
        auto_stop_nxt = auto_stop;
        en_nxt        = pwm_enable;
        dir_nxt       = pwm_direct;
        key_ack_nxt   = 1'b0;
        rmt_ack_nxt   = 1'b0;
        done_nxt      = 1'b0;

        unique case (state)
            S_IDLE: begin
                key_ack_nxt = grant_key;
                rmt_ack_nxt = grant_rmt;
                if ((grant_key || grant_rmt) && cmd != 2'b00) begin
                    state_nxt   = S_RUN;
                    en_nxt      = 1'b1;
                    dir_nxt     = new_dir;
                    run_lim_nxt = run_cycles;
                    cyc_cnt_nxt = '0;
                end
            end
            S_RUN: begin
                if (pwm_flag) begin
                    cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
                end
                // Completion pre-empts any command in the same cycle; the request stays pending.
                if (complete) begin
                    state_nxt     = S_DEAD;
                    en_nxt        = 1'b0;
                    dead_cnt_nxt  = '0;
                    tgt_run_nxt   = 1'b0;
                    auto_stop_nxt = 1'b1;
                end else if (grant_key || grant_rmt) begin
                    key_ack_nxt = grant_key;
                    rmt_ack_nxt = grant_rmt;
                    if (cmd == 2'b00 || new_dir != pwm_direct) begin
                        state_nxt     = S_DEAD;
                        en_nxt        = 1'b0;
                        dead_cnt_nxt  = '0;
                        tgt_run_nxt   = (cmd != 2'b00);
                        tgt_dir_nxt   = new_dir;
                        auto_stop_nxt = 1'b0;
                    end
                end
            end
            S_DEAD: begin
                if (dead_cnt == DEAD_LAST) begin
                    if (tgt_run) begin
                        state_nxt = S_RUN;
                        en_nxt    = 1'b1;
                        dir_nxt   = tgt_dir;
                    end else begin
                        state_nxt = S_IDLE;
                        done_nxt  = auto_stop;
                    end
                end else begin
                    dead_cnt_nxt = dead_cnt + 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge div100_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= S_IDLE;
            dead_cnt   <= '0;
            cyc_cnt    <= '0;
            run_lim    <= '0;
            tgt_run    <= 1'b0;
            tgt_dir    <= 1'b0;
            auto_stop  <= 1'b0;
            key_ack    <= 1'b0;
            rmt_ack    <= 1'b0;
            pwm_enable <= 1'b0;
            pwm_direct <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            dead_cnt   <= dead_cnt_nxt;
            cyc_cnt    <= cyc_cnt_nxt;
            run_lim    <= run_lim_nxt;
            tgt_run    <= tgt_run_nxt;
            tgt_dir    <= tgt_dir_nxt;
            auto_stop  <= auto_stop_nxt;
            key_ack    <= key_ack_nxt;
            rmt_ack    <= rmt_ack_nxt;
            pwm_enable <= en_nxt;
            pwm_direct <= dir_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_motor_seq_ctrl.sv
// Directed self-checking bench for motor_seq_ctrl (default build, key-priority arbitration).
module tb_motor_seq_ctrl;

    logic       div100_clk = 1'b0;
    logic       s_rst_n    = 1'b0;
    logic       key_req    = 1'b0;
    logic [1:0] key_cmd    = 2'b00;
    logic       rmt_req    = 1'b0;
    logic [1:0] rmt_cmd    = 2'b00;
    logic [2:0] run_cycles = 3'd0;
    logic       pwm_flag   = 1'b0;
    logic       key_ack, rmt_ack, pwm_enable, pwm_direct, busy, done;

    int errors = 0;
    int checks = 0;
    int dir_viol = 0;
    int done_cnt = 0;
    logic prev_en = 1'b0;
    logic prev_dir = 1'b0;

    motor_seq_ctrl #(.DEAD_CYCLES(500), .CNT_W(3)) dut (
        .div100_clk (div100_clk),
        .s_rst_n    (s_rst_n),
        .key_req    (key_req),
        .key_cmd    (key_cmd),
        .rmt_req    (rmt_req),
        .rmt_cmd    (rmt_cmd),
        .key_ack    (key_ack),
        .rmt_ack    (rmt_ack),
        .run_cycles (run_cycles),
        .pwm_flag   (pwm_flag),
        .pwm_enable (pwm_enable),
        .pwm_direct (pwm_direct),
        .busy       (busy),
        .done       (done)
    );

    always #5 div100_clk = ~div100_clk;

    // Direction must hold while enabled; done pulses are tallied.
    always @(negedge div100_clk) begin
        if (s_rst_n) begin
            if (prev_en && pwm_enable && pwm_direct != prev_dir) dir_viol++;
            if (done) done_cnt++;
        end
        prev_en  = pwm_enable;
        prev_dir = pwm_direct;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge div100_clk);
        #1;
    endtask

    task automatic wait_enable(output int n);
        n = 0;
        while (!pwm_enable && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic flag_pulse();
        pwm_flag = 1'b1;
        tick();
        pwm_flag = 1'b0;
        tick();
    endtask

    int n;
    int acks;
    int d0;

    initial begin
        #1;
        check("rst_en", pwm_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", key_ack + rmt_ack + done, 0);
        tick();
        s_rst_n = 1'b1;
        tick();

        // Start forward, continuous
        key_cmd = 2'b01; key_req = 1'b1;
        tick();
        check("start_ack", key_ack, 1);
        check("start_en", pwm_enable, 1);
        check("start_dir", pwm_direct, 1);
        check("start_busy", busy, 1);
        key_req = 1'b0;
        tick();
        check("ack_pulse", key_ack, 0);

        // Remote reverse with dead time
        rmt_cmd = 2'b10; rmt_req = 1'b1;
        tick();
        check("rev_ack", rmt_ack, 1);
        check("rev_en_low", pwm_enable, 0);
        check("rev_dir_hold", pwm_direct, 1);
        rmt_req = 1'b0;
        wait_enable(n);
        check("rev_dead_len", n, 500);
        check("rev_dir", pwm_direct, 0);

        // Manual stop: no done
        d0 = done_cnt;
        key_cmd = 2'b00; key_req = 1'b1;
        tick();
        check("stop_ack", key_ack, 1);
        key_req = 1'b0;
        wait_idle(n);
        check("stop_dead_len", n, 500);
        tick();
        check("stop_no_done", done_cnt - d0, 0);

        // Auto-stop after 3 ramp cycles
        run_cycles = 3'd3;
        key_cmd = 2'b01; key_req = 1'b1;
        tick();
        key_req = 1'b0;
        check("auto_run_en", pwm_enable, 1);
        d0 = done_cnt;
        flag_pulse();
        flag_pulse();
        check("auto_2flags_en", pwm_enable, 1);
        pwm_flag = 1'b1;
        tick();
        pwm_flag = 1'b0;
        check("auto_dead_en", pwm_enable, 0);
        check("auto_dead_busy", busy, 1);
        wait_idle(n);
        check("auto_dead_len", n, 500);
        check("auto_done", done, 1);
        tick();
        check("auto_done_pulse", done, 0);
        check("auto_done_cnt", done_cnt - d0, 1);

        // Simultaneous requests in IDLE: key first, remote next
        run_cycles = 3'd0;
        key_cmd = 2'b01; key_req = 1'b1;
        rmt_cmd = 2'b01; rmt_req = 1'b1;
        tick();
        check("arb_key_ack", key_ack, 1);
        check("arb_rmt_wait", rmt_ack, 0);
        key_req = 1'b0;
        tick();
        check("arb_rmt_ack", rmt_ack, 1);
        check("arb_same_dir_en", pwm_enable, 1);
        rmt_req = 1'b0;
        tick();

        // Remote stays pending across DEAD
        key_cmd = 2'b10; key_req = 1'b1;
        rmt_cmd = 2'b00; rmt_req = 1'b1;
        tick();
        check("pend_key_ack", key_ack, 1);
        check("pend_rmt_no", rmt_ack, 0);
        key_req = 1'b0;
        acks = 0;
        n = 0;
        while (!pwm_enable && n < 2000) begin
            tick();
            n++;
            acks += int'(rmt_ack);
        end
        check("pend_dead_len", n, 500);
        check("pend_no_ack_dead", acks, 0);
        check("pend_dir", pwm_direct, 0);
        tick();
        check("pend_rmt_ack", rmt_ack, 1);
        check("pend_stop_en", pwm_enable, 0);
        rmt_req = 1'b0;
        wait_idle(n);
        check("pend_idle_len", n, 500);

        // Completion beats a toggle on the same cycle
        run_cycles = 3'd3;
        key_cmd = 2'b01; key_req = 1'b1;
        tick();
        key_req = 1'b0;
        flag_pulse();
        flag_pulse();
        key_cmd = 2'b11; key_req = 1'b1; pwm_flag = 1'b1;
        tick();
        pwm_flag = 1'b0;
        check("coll_no_ack", key_ack, 0);
        check("coll_en", pwm_enable, 0);
        wait_idle(n);
        check("coll_dead_len", n, 500);
        check("coll_done", done, 1);
        check("coll_ack_dead", key_ack, 0);
        tick();
        check("coll_toggle_ack", key_ack, 1);
        check("coll_toggle_en", pwm_enable, 1);
        check("coll_toggle_dir", pwm_direct, 0);
        key_req = 1'b0;
        tick();

        // Asynchronous reset mid-DEAD
        rmt_cmd = 2'b00; rmt_req = 1'b1;
        tick();
        rmt_req = 1'b0;
        repeat (10) tick();
        check("mid_dead_busy", busy, 1);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_outs", pwm_enable + pwm_direct + key_ack + rmt_ack + done, 0);
        tick();
        s_rst_n = 1'b1;
        tick();
        key_cmd = 2'b01; key_req = 1'b1;
        tick();
        check("post_rst_ack", key_ack, 1);
        check("post_rst_en", pwm_enable, 1);
        check("post_rst_dir", pwm_direct, 1);
        key_req = 1'b0;
        tick();

        check("dir_stable", dir_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
